// File: rtl/matrix_mult_seq_if.sv
// Operand/result memory bus and control handshake for the matrix multiply sequencer.
// master = sequencer side, slave = wrapper/memory side.
interface matrix_mult_seq_if #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int CW = 2 * DW,
    parameter int AW = $clog2(N * N)
);
    logic          start;
    logic          busy;
    logic          done;
    logic          a_rd;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          b_rd;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [CW-1:0] c_data;
    logic          ovf;

    modport master (
        input  start, a_data, b_data,
        output busy, done, a_rd, a_addr, b_rd, b_addr, c_we, c_addr, c_data, ovf
    );

    modport slave (
        output start, a_data, b_data,
        input  busy, done, a_rd, a_addr, b_rd, b_addr, c_we, c_addr, c_data, ovf
    );
endinterface

// File: rtl/matrix_mult_seq.sv
// Sequencer + MAC datapath computing C = A x B over synchronous-read operand RAMs.
// Optional saturation of C elements (with sticky ovf) is enabled by defining MATRIX_SAT_EN.
module matrix_mult_seq #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int CW = 2 * DW,
    parameter int AW = $clog2(N * N)
) (
    input  logic                clk,
    input  logic                rst,
    matrix_mult_seq_if.master   bus
);
    localparam int IW = $clog2(N);
`ifdef MATRIX_SAT_EN
    localparam int ACCW = 2 * DW + $clog2(N);
    localparam logic [ACCW-1:0] CMAX = (ACCW'(1) << CW) - ACCW'(1);
`else
    // A mod-2^CW sum equals the low CW bits of the wide sum, so truncation needs no extra bits.
    localparam int ACCW = CW;
`endif

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   i_reg, i_next, j_reg, j_next, k_reg, k_next;
    logic [ACCW-1:0] acc_reg, acc_next;
    logic            rd_vld_reg;
    logic [ACCW-1:0] prod;

    function automatic logic [AW-1:0] idx(input logic [IW-1:0] r, input logic [IW-1:0] c);
        return AW'(int'(r) * N + int'(c));
    endfunction

    assign prod = ACCW'(bus.a_data) * ACCW'(bus.b_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            i_reg      <= '0;
            j_reg      <= '0;
            k_reg      <= '0;
            acc_reg    <= '0;
            rd_vld_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            i_reg      <= i_next;
            j_reg      <= j_next;
            k_reg      <= k_next;
            acc_reg    <= acc_next;
            rd_vld_reg <= (state_reg == RUN);
        end
    end

    always_comb begin
        state_next = state_reg;
        i_next     = i_reg;
        j_next     = j_reg;
        k_next     = k_reg;
        acc_next   = acc_reg;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        bus.a_rd   = 1'b0;
        bus.a_addr = '0;
        bus.b_rd   = 1'b0;
        bus.b_addr = '0;
        bus.c_we   = 1'b0;
        bus.c_addr = '0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                    i_next     = '0;
                    j_next     = '0;
                    k_next     = '0;
                    acc_next   = '0;
                end
            end
            RUN: begin
                bus.busy   = 1'b1;
                bus.a_rd   = 1'b1;
                bus.b_rd   = 1'b1;
                bus.a_addr = idx(i_reg, k_reg);
                bus.b_addr = idx(k_reg, j_reg);
                // k == 0 starts a fresh element; the product arriving then belongs to nothing.
                acc_next   = ((k_reg == '0) ? '0 : acc_reg) + (rd_vld_reg ? prod : '0);
                if (k_reg == IW'(N - 1)) begin
                    k_next     = '0;
                    state_next = DRAIN;
                end else begin
                    k_next = k_reg + IW'(1);
                end
            end
            DRAIN: begin
                bus.busy   = 1'b1;
                acc_next   = acc_reg + (rd_vld_reg ? prod : '0);
                state_next = WRITE;
            end
            WRITE: begin
                bus.busy   = 1'b1;
                bus.c_we   = 1'b1;
                bus.c_addr = idx(i_reg, j_reg);
                if (j_reg == IW'(N - 1)) begin
                    j_next = '0;
                    i_next = i_reg + IW'(1);
                end else begin
                    j_next = j_reg + IW'(1);
                end
                if (i_reg == IW'(N - 1) && j_reg == IW'(N - 1))
                    state_next = DONE;
                else
                    state_next = RUN;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef MATRIX_SAT_EN
    logic ovf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_reg <= 1'b0;
        else if (state_reg == IDLE && bus.start)
            ovf_reg <= 1'b0;
        else if (state_reg == WRITE && acc_reg > CMAX)
            ovf_reg <= 1'b1;
    end

    assign bus.c_data = (acc_reg > CMAX) ? {CW{1'b1}} : acc_reg[CW-1:0];
    assign bus.ovf    = ovf_reg;
`else
    assign bus.c_data = acc_reg;
    assign bus.ovf    = 1'b0;
`endif
endmodule

// File: tb/tb_matrix_mult_seq.sv
// Scoreboarded random/directed bench for matrix_mult_seq against an arithmetic C = A x B model.
module tb_matrix_mult_seq;
    localparam int N  = 2;
    localparam int DW = 8;
    localparam int CW = 2 * DW;
    localparam int AW = $clog2(N * N);
    localparam int NE = N * N;
    localparam int DONE_CYC = N * N * (N + 2) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matrix_mult_seq_if #(.N(N), .DW(DW), .CW(CW), .AW(AW)) bus();
    matrix_mult_seq #(.N(N), .DW(DW), .CW(CW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [DW-1:0] a_mem [NE];
    logic [DW-1:0] b_mem [NE];

    always @(posedge clk) begin
        if (bus.a_rd) bus.a_data <= a_mem[bus.a_addr];
        if (bus.b_rd) bus.b_data <= b_mem[bus.b_addr];
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   wr_cnt   = 0;
    logic exp_ovf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain matrix arithmetic, then truncate or saturate to CW bits.
    task automatic load_and_expect();
        longint cmax = (64'd1 << CW) - 1;
        exp_ovf = 1'b0;
        for (int e = 0; e < NE; e++) begin
            longint sum = 0;
            wr_t w;
            for (int k = 0; k < N; k++)
                sum += longint'(a_mem[(e / N) * N + k]) * longint'(b_mem[k * N + (e % N)]);
            w.addr = AW'(e);
`ifdef MATRIX_SAT_EN
            if (sum > cmax) begin
                w.data  = {CW{1'b1}};
                exp_ovf = 1'b1;
            end else begin
                w.data = CW'(sum);
            end
`else
            w.data = CW'(sum & cmax);
`endif
            exp_q.push_back(w);
        end
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        if (!rst) begin
            check("b_rd_eq_a_rd", 64'(bus.b_rd), 64'(bus.a_rd));
            if (!bus.a_rd) begin
                check("a_addr_idle", 64'(bus.a_addr), 64'd0);
                check("b_addr_idle", 64'(bus.b_addr), 64'd0);
            end
            if (bus.c_we) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%0d data=%0h required=no_write", bus.c_addr, bus.c_data);
                end else begin
                    e = exp_q.pop_front();
                    $display("write C[%0d] = 0x%04h (expected C[%0d] = 0x%04h)", bus.c_addr, bus.c_data, e.addr, e.data);
                    check("c_addr", 64'(bus.c_addr), 64'(e.addr));
                    check("c_data", 64'(bus.c_data), 64'(e.data));
                end
            end else begin
                check("c_addr_idle", 64'(bus.c_addr), 64'd0);
            end
        end
    end

    // Call at a negedge; returns at the negedge of the done cycle (or the one after, with extras).
    task automatic run_mult(input bit extra_starts);
        int cyc;
        load_and_expect();
        wr_cnt = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        check("busy_after_start", 64'(bus.busy), 64'd1);
        check("done_not_sticky", 64'(bus.done), 64'd0);
        check("ovf_cleared", 64'(bus.ovf), 64'd0);
        while (!bus.done && cyc < 200) begin
            bus.start = (extra_starts && cyc == 5);
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check("done_cycle", 64'(cyc), 64'(DONE_CYC));
        check("busy_in_done", 64'(bus.busy), 64'd0);
        check("ovf_at_done", 64'(bus.ovf), 64'(exp_ovf));
        check("write_count", 64'(wr_cnt), 64'(NE));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("run done at cycle %0d, writes=%0d ovf=%0b", cyc, wr_cnt, bus.ovf);
        if (extra_starts) begin
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            check("start_in_done_ignored", 64'(bus.busy), 64'd0);
            check("done_one_pulse", 64'(bus.done), 64'd0);
        end
    endtask

    task automatic set_mats(input logic [DW-1:0] a [NE], input logic [DW-1:0] b [NE]);
        for (int e = 0; e < NE; e++) begin
            a_mem[e] = a[e];
            b_mem[e] = b[e];
        end
    endtask

    task automatic rand_mats();
        for (int e = 0; e < NE; e++) begin
            a_mem[e] = DW'($urandom);
            b_mem[e] = DW'($urandom);
        end
    endtask

    initial begin
        logic [DW-1:0] ma [NE];
        logic [DW-1:0] mb [NE];
        int cyc;
        bus.start  = 1'b0;
        bus.a_data = '0;
        bus.b_data = '0;
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_c_we", 64'(bus.c_we), 64'd0);
        check("rst_a_rd", 64'(bus.a_rd), 64'd0);
        check("rst_c_data", 64'(bus.c_data), 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 64'(bus.busy), 64'd0);

        ma = '{8'd1, 8'd2, 8'd3, 8'd4};
        mb = '{8'd5, 8'd6, 8'd7, 8'd8};
        set_mats(ma, mb);
        run_mult(1'b0);
        @(negedge clk);
        check("busy_low_after", 64'(bus.busy), 64'd0);
        repeat (2) @(negedge clk);

        ma = '{8'd1, 8'd0, 8'd0, 8'd1};
        mb = '{8'd9, 8'd8, 8'd7, 8'd6};
        set_mats(ma, mb);
        run_mult(1'b0);
        repeat (3) @(negedge clk);

        ma = '{8'd255, 8'd255, 8'd255, 8'd255};
        set_mats(ma, ma);
        run_mult(1'b0);
        repeat (3) @(negedge clk);

        rand_mats();
        run_mult(1'b1);
        repeat (4) @(negedge clk);

        // Abort during the write of C[1], then rerun from scratch.
        ma = '{8'd1, 8'd2, 8'd3, 8'd4};
        mb = '{8'd5, 8'd6, 8'd7, 8'd8};
        set_mats(ma, mb);
        load_and_expect();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!(bus.c_we && bus.c_addr == AW'(1)) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_write_c1", 64'(cyc < 100), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_c_we", 64'(bus.c_we), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_a_rd", 64'(bus.a_rd), 64'd0);
        check("abort_c_addr", 64'(bus.c_addr), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_stays_idle", 64'(bus.busy), 64'd0);
        run_mult(1'b0);
        repeat (2) @(negedge clk);

        rand_mats();
        run_mult(1'b0);
        @(negedge clk);
        run_mult(1'b0);
        repeat (3) @(negedge clk);

        for (int r = 0; r < 3; r++) begin
            rand_mats();
            run_mult(1'b0);
            repeat (1 + r) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
